// File: rtl/matmul_sequencer.sv
// Loop-nest sequencer for C = A x B over DIM x DIM matrices: issues A/B reads,
// MAC controls and C writes. Optional build macro: MATMUL_SEQ_AUTOSTART_EN.
module matmul_sequencer #(
  parameter int DIM = 4,
  localparam int IDX_W = $clog2(DIM),
  localparam int AW = 2 * IDX_W
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done_computing,
  output logic          rd_en,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr,
  output logic          mac_en,
  output logic          mac_clear,
  output logic          c_we,
  output logic [AW-1:0] c_addr
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIM - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  // Drain spans the P1 and P2 stages plus the edge that performs the last C write.
  localparam logic [1:0] DRAIN_LAST = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [1:0]       drain_reg, drain_next;
  logic [IDX_W-1:0] i_reg, i_next;
  logic [IDX_W-1:0] j_reg, j_next;
  logic [IDX_W-1:0] k_reg, k_next;
  logic             autostart_req;

  logic             p1_mac_en_reg, p1_clear_reg, p1_last_k_reg;
  logic [IDX_W-1:0] p1_i_reg, p1_j_reg;
  logic             p2_we_reg;
  logic [IDX_W-1:0] p2_i_reg, p2_j_reg;

`ifdef MATMUL_SEQ_AUTOSTART_EN
  logic autostart_pending_reg;

  // High only for the first cycle after reset is released.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) autostart_pending_reg <= 1'b1;
    else       autostart_pending_reg <= 1'b0;
  end

  assign autostart_req = autostart_pending_reg;
`else
  assign autostart_req = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    drain_next = drain_reg;
    i_next     = i_reg;
    j_next     = j_reg;
    k_next     = k_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start || autostart_req) begin
          state_next = S_RUN;
          i_next     = '0;
          j_next     = '0;
          k_next     = '0;
        end
      end
      S_RUN: begin
        k_next = k_reg + IDX_ONE;
        if (k_reg == IDX_MAX) begin
          j_next = j_reg + IDX_ONE;
          if (j_reg == IDX_MAX) begin
            i_next = i_reg + IDX_ONE;
            if (i_reg == IDX_MAX) begin
              state_next = S_DRAIN;
              drain_next = 2'd0;
            end
          end
        end
      end
      S_DRAIN: begin
        if (drain_reg == DRAIN_LAST) state_next = S_DONE;
        else                         drain_next = drain_reg + 2'd1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      drain_reg <= 2'd0;
      i_reg     <= '0;
      j_reg     <= '0;
      k_reg     <= '0;
    end else begin
      state_reg <= state_next;
      drain_reg <= drain_next;
      i_reg     <= i_next;
      j_reg     <= j_next;
      k_reg     <= k_next;
    end
  end

  assign rd_en          = (state_reg == S_RUN);
  assign busy           = rd_en || (state_reg == S_DRAIN);
  assign done_computing = (state_reg == S_DONE);
  assign a_addr         = rd_en ? {i_reg, k_reg} : '0;
  assign b_addr         = rd_en ? {k_reg, j_reg} : '0;

  // P1 aligns with read data returning; P2 aligns with the finished accumulator.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p1_mac_en_reg <= 1'b0;
      p1_clear_reg  <= 1'b0;
      p1_last_k_reg <= 1'b0;
      p1_i_reg      <= '0;
      p1_j_reg      <= '0;
      p2_we_reg     <= 1'b0;
      p2_i_reg      <= '0;
      p2_j_reg      <= '0;
    end else begin
      p1_mac_en_reg <= rd_en;
      p1_clear_reg  <= rd_en && (k_reg == '0);
      p1_last_k_reg <= rd_en && (k_reg == IDX_MAX);
      p1_i_reg      <= i_reg;
      p1_j_reg      <= j_reg;
      p2_we_reg     <= p1_mac_en_reg && p1_last_k_reg;
      p2_i_reg      <= p1_i_reg;
      p2_j_reg      <= p1_j_reg;
    end
  end

  assign mac_en    = p1_mac_en_reg;
  assign mac_clear = p1_clear_reg;
  assign c_we      = p2_we_reg;
  assign c_addr    = p2_we_reg ? {p2_i_reg, p2_j_reg} : '0;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Randomized bench for matmul_sequencer; expected outputs come from a model
// indexed by cycles elapsed since the accepted start.
`timescale 1ns/1ps
module tb_matmul_sequencer;
  localparam int DIM     = 4;
  localparam int IDX_W   = $clog2(DIM);
  localparam int AW      = 2 * IDX_W;
  localparam int N_ISSUE = DIM * DIM * DIM;
  localparam int DONE_T  = N_ISSUE + 3;
  localparam int VW      = 6 + 3 * AW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done_computing, rd_en, mac_en, mac_clear, c_we;
  logic [AW-1:0] a_addr, b_addr, c_addr;
  logic [VW-1:0] obs, expv;

  int tests_run    = 0;
  int tests_failed = 0;
  int ref_t        = -1;   // cycles since the run-start edge; -1 = idle
  bit autostart_armed = 1'b0;

  matmul_sequencer #(.DIM(DIM)) dut (
    .clock(clock), .reset(reset), .start(start),
    .busy(busy), .done_computing(done_computing), .rd_en(rd_en),
    .a_addr(a_addr), .b_addr(b_addr), .mac_en(mac_en), .mac_clear(mac_clear),
    .c_we(c_we), .c_addr(c_addr)
  );

  always #5 clock = ~clock;

  assign obs = {busy, done_computing, rd_en, a_addr, b_addr, mac_en, mac_clear, c_we, c_addr};

  // Expected outputs t cycles after the edge that accepted start.
  function automatic logic [VW-1:0] model(input int t);
    logic busy_e, done_e, rd_e, mac_e, clr_e, we_e;
    logic [AW-1:0] a_e, b_e, c_e;
    int ii, jj, kk;
    busy_e = 0; done_e = 0; rd_e = 0; mac_e = 0; clr_e = 0; we_e = 0;
    a_e = '0; b_e = '0; c_e = '0;
    if (t >= 0 && t < DONE_T) busy_e = 1;
    if (t >= DONE_T) done_e = 1;
    if (t >= 0 && t < N_ISSUE) begin
      ii = t / (DIM * DIM);
      jj = (t / DIM) % DIM;
      kk = t % DIM;
      rd_e = 1;
      a_e = AW'(ii * DIM + kk);
      b_e = AW'(kk * DIM + jj);
    end
    if (t >= 1 && t <= N_ISSUE) begin
      mac_e = 1;
      clr_e = ((t - 1) % DIM == 0);
    end
    if (t >= 2 && t <= N_ISSUE + 1 && ((t - 2) % DIM) == DIM - 1) begin
      we_e = 1;
      c_e = AW'((t - 2) / DIM);
    end
    return {busy_e, done_e, rd_e, a_e, b_e, mac_e, clr_e, we_e, c_e};
  endfunction

  // Advance one clock and update the reference timeline from the sampled start.
  task automatic step();
    logic s;
    s = start;
    @(posedge clock);
    if (reset) ref_t = -1;
    else if (autostart_armed) begin
      ref_t = 0;
      autostart_armed = 1'b0;
    end else if (s && (ref_t < 0 || ref_t >= DONE_T)) ref_t = 0;
    else if (ref_t >= 0 && ref_t < DONE_T + 1000) ref_t++;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    ref_t = -1;
    expv = model(ref_t);
    tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("FAIL reset_state got %h expected %h", obs, expv);
    end
    reset = 1'b0;
`ifdef MATMUL_SEQ_AUTOSTART_EN
    autostart_armed = 1'b1;
`endif
  endtask

`ifdef MATMUL_SEQ_AUTOSTART_EN
  task automatic test_autostart();
    start = 1'b0;
    repeat (DONE_T + 10) begin
      step();
      expv = model(ref_t);
      tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("FAIL autostart t=%0d got %h expected %h", ref_t, obs, expv);
      end
    end
  endtask
`else
  task automatic test_idle();
    start = 1'b0;
    repeat (10) begin
      step();
      expv = model(ref_t);
      tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("FAIL idle t=%0d got %h expected %h", ref_t, obs, expv);
      end
    end
  endtask
`endif

  task automatic test_single_run();
    start = 1'b0;
    repeat ($urandom_range(0, 4)) step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (DONE_T + 4) begin
      expv = model(ref_t);
      tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("FAIL single_run t=%0d got %h expected %h", ref_t, obs, expv);
      end
      step();
    end
  endtask

  task automatic test_ignored_start();
    int extra;
    extra = int'($urandom_range(1, 60));
    start = 1'b1;
    step();
    repeat (DONE_T + 4) begin
      start = (ref_t == 20 || ref_t == extra) ? 1'b1 : 1'b0;
      expv = model(ref_t);
      tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("FAIL ignored_start t=%0d got %h expected %h", ref_t, obs, expv);
      end
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_mid_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 0; n < 40 && ref_t < 30; n++) begin
      step();
      expv = model(ref_t);
      tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("FAIL pre_reset t=%0d got %h expected %h", ref_t, obs, expv);
      end
    end
    reset = 1'b1;
    ref_t = -1;
    #1;
    expv = model(ref_t);
    tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("FAIL reset_immediate got %h expected %h", obs, expv);
    end
    repeat (2) begin
      step();
      expv = model(ref_t);
      tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("FAIL reset_held got %h expected %h", obs, expv);
      end
    end
    reset = 1'b0;
`ifdef MATMUL_SEQ_AUTOSTART_EN
    autostart_armed = 1'b1;
`endif
    repeat (3) begin
      step();
      expv = model(ref_t);
      tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("FAIL post_reset t=%0d got %h expected %h", ref_t, obs, expv);
      end
    end
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (DONE_T + 3) begin
      expv = model(ref_t);
      tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("FAIL rerun t=%0d got %h expected %h", ref_t, obs, expv);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    repeat (2 * (DONE_T + 1) + 3) begin
      step();
      expv = model(ref_t);
      tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("FAIL back_to_back t=%0d got %h expected %h", ref_t, obs, expv);
      end
    end
    start = 1'b0;
    repeat (DONE_T + 3) begin
      step();
      expv = model(ref_t);
      tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("FAIL back_to_back_tail t=%0d got %h expected %h", ref_t, obs, expv);
      end
    end
  endtask

  task automatic test_random_start();
    repeat (400) begin
      start = ($urandom_range(0, 9) == 0);
      step();
      expv = model(ref_t);
      tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("FAIL random_start t=%0d got %h expected %h", ref_t, obs, expv);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
`ifdef MATMUL_SEQ_AUTOSTART_EN
    test_autostart();
`else
    test_idle();
`endif
    test_single_run();
    test_ignored_start();
    test_mid_reset();
    test_back_to_back();
    test_random_start();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
